// File: rtl/jk_excitation_driver.sv
// Table-driven stimulus sequencer and self-checker for a bank of negedge JK flops.
// Optional build macro JK_DRIVER_TOGGLE_EN: changing bits are driven as toggles instead of set/reset.
module jk_excitation_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     not_RST,
    input  logic                     clear,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    input  logic                     start,
    input  logic [WIDTH-1:0]         Q_fb,
    output logic [WIDTH-1:0]         J,
    output logic [WIDTH-1:0]         K,
    output logic                     busy,
    output logic                     done,
    output logic                     mismatch,
    output logic [$clog2(DEPTH)-1:0] fail_idx
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic            mismatch_q, mismatch_d;
    logic [IW-1:0]   fail_idx_q, fail_idx_d;

    logic [WIDTH-1:0] table_mem [DEPTH];
    logic             wr_en;
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    chk_idx;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] check_val;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic             table_full;

    assign rd_idx     = idx_q[IW-1:0];
    assign chk_idx    = rd_idx - IW'(1);
    assign target     = table_mem[rd_idx];
    assign check_val  = table_mem[chk_idx];
    assign table_full = (count_q == CW'(DEPTH));

    // Per-bit excitation from the bank's present state toward the target entry.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_DRIVER_TOGGLE_EN
        assign j_exc[gi] = Q_fb[gi] ^ target[gi];
        assign k_exc[gi] = Q_fb[gi] ^ target[gi];
`else
        assign j_exc[gi] = ~Q_fb[gi] & target[gi];
        assign k_exc[gi] = Q_fb[gi] & ~target[gi];
`endif
    end

    assign load_ready = (state_q == S_IDLE) && !table_full && !start;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        j_d        = '0;
        k_d        = '0;
        mismatch_d = mismatch_q;
        fail_idx_d = fail_idx_q;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_q != '0) begin
                        state_d    = S_RUN;
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        fail_idx_d = '0;
                    end
                end else if (clear) begin
                    count_d = '0;
                end else if (load_valid && load_ready) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            S_RUN: begin
                // idx == count is the extra cycle that only checks the last entry.
                if (idx_q != count_q) begin
                    j_d   = j_exc;
                    k_d   = k_exc;
                    idx_d = idx_q + CW'(1);
                end else begin
                    state_d = S_DONE;
                end
                if ((idx_q != '0) && (Q_fb != check_val)) begin
                    mismatch_d = 1'b1;
                    if (!mismatch_q) begin
                        fail_idx_d = chk_idx;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge not_RST) begin
        if (!not_RST) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            j_q        <= j_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // Table storage is not reset; count alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            table_mem[count_q[IW-1:0]] <= load_data;
        end
    end

    assign J        = j_q;
    assign K        = k_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign mismatch = mismatch_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: a behavioural negedge JK bank with stuck-at-0 faults,
// directed scenarios plus randomized tables checked against a table-walk model.
module tb_jk_excitation_driver;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic             CLK = 1'b0;
    logic             not_RST;
    logic             clear;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             start;
    logic [WIDTH-1:0] Q_fb;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [2:0]       fail_idx;

    logic [WIDTH-1:0] bank_q = '0;
    logic [WIDTH-1:0] bank_val;
    logic             bank_set;
    logic [WIDTH-1:0] stuck0;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_tab [DEPTH];
    int               model_count = 0;

    always #5 CLK = ~CLK;

    jk_excitation_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .not_RST(not_RST), .clear(clear), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .start(start), .Q_fb(Q_fb),
        .J(J), .K(K), .busy(busy), .done(done), .mismatch(mismatch), .fail_idx(fail_idx)
    );

    // Flop bank: standard JK next-state on negedge, outputs forced low on stuck bits.
    always @(negedge CLK) begin
        if (bank_set) bank_q <= bank_val;
        else          bank_q <= (J & ~bank_q) | (~K & bank_q);
    end
    assign Q_fb = bank_q & ~stuck0;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Required J/K for one step, straight from the excitation table of a JK flop.
    function automatic logic [2*WIDTH-1:0] jk_for(input logic [WIDTH-1:0] from_q,
                                                  input logic [WIDTH-1:0] to_q);
        logic [WIDTH-1:0] jj, kk;
        for (int b = 0; b < WIDTH; b++) begin
            if (from_q[b] == to_q[b]) begin
                jj[b] = 1'b0; kk[b] = 1'b0;
            end else begin
`ifdef JK_DRIVER_TOGGLE_EN
                jj[b] = 1'b1; kk[b] = 1'b1;
`else
                jj[b] = to_q[b]; kk[b] = from_q[b];
`endif
            end
        end
        return {jj, kk};
    endfunction

    task automatic load(input logic [WIDTH-1:0] v);
        load_data  = v;
        load_valid = 1'b1;
        #1;
        check("load_ready", {31'd0, load_ready}, {31'd0, model_count < DEPTH});
        tick();
        if (model_count < DEPTH) begin
            model_tab[model_count] = v;
            model_count++;
        end
        load_valid = 1'b0;
    endtask

    task automatic clear_table();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_count = 0;
    endtask

    task automatic walk(input logic [WIDTH-1:0] init, input logic [WIDTH-1:0] stuck,
                        input bit with_load, input bit with_clear);
        logic [WIDTH-1:0]   prev, fb_next;
        logic [2*WIDTH-1:0] ejk;
        int                 exp_fi, busy_cycles;
        bit                 exp_mm;
        bank_val = init;
        bank_set = 1'b1;
        stuck0   = stuck;
        tick();
        bank_set = 1'b0;
        start    = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_data  = WIDTH'($urandom);
        end
        #1;
        check("ready_when_start", {31'd0, load_ready}, 32'd0);
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        busy_cycles = busy ? 1 : 0;
        check("run_entry_busy", {31'd0, busy}, 32'd1);
        check("run_entry_J", {28'd0, J}, 32'd0);
        prev   = init & ~stuck;
        exp_mm = 1'b0;
        exp_fi = 0;
        for (int i = 0; i < model_count; i++) begin
            if (with_clear && i == 1) begin
                clear      = 1'b1;
                load_valid = 1'b1;
            end
            #1;
            if (with_clear && i == 1)
                check("ready_in_run", {31'd0, load_ready}, 32'd0);
            tick();
            clear      = 1'b0;
            load_valid = 1'b0;
            ejk = jk_for(prev, model_tab[i]);
            $display("step %0d target=%b Q_fb=%b J=%b K=%b", i, model_tab[i], Q_fb, J, K);
            check("step_Qfb", {28'd0, Q_fb}, {28'd0, prev});
            check("step_J", {28'd0, J}, {28'd0, ejk[2*WIDTH-1:WIDTH]});
            check("step_K", {28'd0, K}, {28'd0, ejk[WIDTH-1:0]});
            check("step_done", {31'd0, done}, 32'd0);
            if (busy) busy_cycles++;
            fb_next = model_tab[i] & ~stuck;
            if (fb_next != model_tab[i] && !exp_mm) begin
                exp_mm = 1'b1;
                exp_fi = i;
            end
            prev = fb_next;
        end
        tick();
        $display("walk end n=%0d done=%b mismatch=%b fail_idx=%0d", model_count, done, mismatch, fail_idx);
        check("end_Qfb", {28'd0, Q_fb}, {28'd0, prev});
        check("end_J", {28'd0, J}, 32'd0);
        check("end_K", {28'd0, K}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, done}, 32'd1);
        check("busy_cycles", busy_cycles, model_count + 1);
        check("mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
        check("fail_idx", {29'd0, fail_idx}, exp_fi);
        tick();
        check("post_done", {31'd0, done}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
        check("post_ready", {31'd0, load_ready}, {31'd0, model_count < DEPTH});
    endtask

    initial begin
        not_RST    = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        bank_set   = 1'b0;
        bank_val   = '0;
        stuck0     = '0;
        #12;
        check("rst_J", {28'd0, J}, 32'd0);
        check("rst_K", {28'd0, K}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mismatch", {31'd0, mismatch}, 32'd0);
        check("rst_fail_idx", {29'd0, fail_idx}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        #5 not_RST = 1'b1;
        tick();

        // start on an empty table is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("empty start busy=%b", busy);
        check("empty_start_busy", {31'd0, busy}, 32'd0);
        tick();
        check("empty_start_busy2", {31'd0, busy}, 32'd0);

        // directed table from bank state 0000
        load(4'b0001); load(4'b0011); load(4'b0110); load(4'b0000);
        walk(4'b0000, 4'b0000, 1'b0, 1'b0);
        // clear and loads during RUN are ignored; table then replays
        walk(4'b0000, 4'b0000, 1'b0, 1'b1);
        walk(4'b0000, 4'b0000, 1'b0, 1'b0);

        // bit0 stuck low
        clear_table();
        load(4'b0001); load(4'b0000);
        walk(4'b0000, 4'b0001, 1'b0, 1'b0);

        // full table: extra write dropped, start+load_valid starts with no write
        clear_table();
        for (int i = 0; i < DEPTH; i++) load(WIDTH'($urandom));
        load(4'b1010);
        check("full_count", model_count, DEPTH);
        walk(WIDTH'($urandom), 4'b0000, 1'b1, 1'b0);

        // randomized tables, initial states and stuck faults
        for (int r = 0; r < 20; r++) begin
            int n;
            logic [WIDTH-1:0] stk;
            n = $urandom_range(1, DEPTH);
            clear_table();
            for (int i = 0; i < n; i++) load(WIDTH'($urandom));
            stk = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : '0;
            walk(WIDTH'($urandom), stk, 1'b0, 1'b0);
        end

        // asynchronous reset mid-walk at idx 2, with a failure already recorded
        clear_table();
        load(4'b0001); load(4'b0011); load(4'b0111); load(4'b1111);
        bank_val = '0;
        bank_set = 1'b1;
        stuck0   = 4'b0001;
        tick();
        bank_set = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_mismatch", {31'd0, mismatch}, 32'd1);
        not_RST = 1'b0;
        #1;
        $display("mid-walk reset J=%b K=%b busy=%b mismatch=%b", J, K, busy, mismatch);
        check("midrst_J", {28'd0, J}, 32'd0);
        check("midrst_K", {28'd0, K}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_mismatch", {31'd0, mismatch}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_fail_idx", {29'd0, fail_idx}, 32'd0);
        #2 not_RST = 1'b1;
        stuck0 = '0;
        model_count = 0;
        #1;
        check("midrst_ready", {31'd0, load_ready}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_count0_busy", {31'd0, busy}, 32'd0);
        tick();
        check("midrst_count0_busy2", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
